// File: rtl/sky130_fd_io__xres4v2_ctrl.sv
// XRES pad controller: orders the pad enables, holds the pad mode pins and turns the raw
// XRES_H_N into a synchronised, glitch-filtered, stretched system reset with an event count.
module sky130_fd_io__xres4v2_ctrl #(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned FILT_CYC    = 8,
  parameter int unsigned STRETCH_CYC = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RESET_B,
  input  logic             PWR_REQ,
  input  logic             CFG_INP_SEL,
  input  logic             CFG_VDDIO_SIG,
  input  logic             CFG_DIS_PULLUP,
  input  logic             CNT_CLR,
  input  logic             XRES_H_N,
  output logic             ENABLE_VDDIO,
  output logic             ENABLE_H,
  output logic             INP_SEL_H,
  output logic             EN_VDDIO_SIG_H,
  output logic             DISABLE_PULLUP_H,
  output logic             SYS_RST_N,
  output logic             READY,
  output logic [2:0]       STATE,
  output logic             RST_EVT,
  output logic [CNT_W-1:0] RST_CNT
);

  typedef enum logic [2:0] {
    StOff    = 3'd0,
    StVioUp  = 3'd1,
    StSettle = 3'd2,
    StRun    = 3'd3,
    StEnDn   = 3'd4
  } state_e;

  localparam int unsigned SeqMax  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned CcntMax = (SeqMax > FILT_CYC + 2) ? SeqMax : FILT_CYC + 2;
  localparam int unsigned CW      = $clog2(CcntMax + 1);
  localparam int unsigned FW      = $clog2(FILT_CYC + 1);
  localparam int unsigned SW      = $clog2(STRETCH_CYC + 1);

  localparam logic [CW-1:0] SetupLast   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HoldLast    = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] SettleLast  = CW'(FILT_CYC + 1);
  localparam logic [FW-1:0] FiltLast    = FW'(FILT_CYC - 1);
  localparam logic [SW-1:0] StretchLoad = SW'(STRETCH_CYC);

  state_e             state_q, state_d;
  logic [CW-1:0]      ccnt_q, ccnt_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic [SW-1:0]      scnt_q, scnt_d;
  logic               sync1_q, sync_q;
  logic               filt_q, filt_d;
  logic               en_vddio_q, en_vddio_d;
  logic               en_h_q, en_h_d;
  logic               inp_sel_q, inp_sel_d;
  logic               vddio_sig_q, vddio_sig_d;
  logic               dis_pu_q, dis_pu_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               rst_evt_q, rst_evt_d;
  logic [CNT_W-1:0]   rst_cnt_q, rst_cnt_d;

  always_comb begin
    state_d     = state_q;
    ccnt_d      = ccnt_q + CW'(1);
    en_vddio_d  = en_vddio_q;
    en_h_d      = en_h_q;
    inp_sel_d   = inp_sel_q;
    vddio_sig_d = vddio_sig_q;
    dis_pu_d    = dis_pu_q;
    filt_d      = filt_q;
    fcnt_d      = '0;

    // Filter: a level change is accepted only after FILT_CYC consecutive differing samples.
    if (sync_q != filt_q) begin
      if (fcnt_q == FiltLast) begin
        filt_d = sync_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    unique case (state_q)
      StOff: begin
        ccnt_d = '0;
        if (PWR_REQ) begin
          inp_sel_d   = CFG_INP_SEL;
          vddio_sig_d = CFG_VDDIO_SIG;
          dis_pu_d    = CFG_DIS_PULLUP;
          en_vddio_d  = 1'b1;
          state_d     = StVioUp;
        end
      end
      StVioUp: begin
        if (!PWR_REQ) begin
          en_vddio_d = 1'b0;
          ccnt_d     = '0;
          state_d    = StOff;
        end else if (ccnt_q == SetupLast) begin
          en_h_d  = 1'b1;
          ccnt_d  = '0;
          filt_d  = sync_q;
          fcnt_d  = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (!PWR_REQ) begin
          en_h_d  = 1'b0;
          ccnt_d  = '0;
          state_d = StEnDn;
        end else if (ccnt_q == SettleLast) begin
          ccnt_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        ccnt_d = '0;
        if (!PWR_REQ) begin
          en_h_d  = 1'b0;
          state_d = StEnDn;
        end
      end
      StEnDn: begin
        // Runs to completion regardless of PWR_REQ so the hold time is always honoured.
        if (ccnt_q == HoldLast) begin
          en_vddio_d = 1'b0;
          ccnt_d     = '0;
          state_d    = StOff;
        end
      end
      default: begin
        en_vddio_d = 1'b0;
        en_h_d     = 1'b0;
        ccnt_d     = '0;
        state_d    = StOff;
      end
    endcase

    // Stretch only counts on a release seen while already in RUN; a fall abandons it.
    scnt_d = scnt_q;
    if (state_d != StRun || !filt_d) begin
      scnt_d = '0;
    end else if (state_q == StRun && !filt_q) begin
      scnt_d = StretchLoad;
    end else if (scnt_q != '0) begin
      scnt_d = scnt_q - SW'(1);
    end

    sys_rst_n_d = (state_d == StRun) && filt_d && (scnt_d == '0);
    ready_d     = (state_d == StRun);
    rst_evt_d   = (state_q == StRun) && (state_d == StRun) && filt_q && !filt_d;

    rst_cnt_d = rst_cnt_q;
    if (CNT_CLR) begin
      rst_cnt_d = '0;
    end else if (rst_evt_d && rst_cnt_q != {CNT_W{1'b1}}) begin
      rst_cnt_d = rst_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q     <= StOff;
      ccnt_q      <= '0;
      fcnt_q      <= '0;
      scnt_q      <= '0;
      sync1_q     <= 1'b0;
      sync_q      <= 1'b0;
      filt_q      <= 1'b0;
      en_vddio_q  <= 1'b0;
      en_h_q      <= 1'b0;
      inp_sel_q   <= 1'b0;
      vddio_sig_q <= 1'b1;
      dis_pu_q    <= 1'b0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      rst_evt_q   <= 1'b0;
      rst_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ccnt_q      <= ccnt_d;
      fcnt_q      <= fcnt_d;
      scnt_q      <= scnt_d;
      sync1_q     <= XRES_H_N;
      sync_q      <= sync1_q;
      filt_q      <= filt_d;
      en_vddio_q  <= en_vddio_d;
      en_h_q      <= en_h_d;
      inp_sel_q   <= inp_sel_d;
      vddio_sig_q <= vddio_sig_d;
      dis_pu_q    <= dis_pu_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      rst_evt_q   <= rst_evt_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  assign ENABLE_VDDIO     = en_vddio_q;
  assign ENABLE_H         = en_h_q;
  assign INP_SEL_H        = inp_sel_q;
  assign EN_VDDIO_SIG_H   = vddio_sig_q;
  assign DISABLE_PULLUP_H = dis_pu_q;
  assign SYS_RST_N        = sys_rst_n_q;
  assign READY            = ready_q;
  assign STATE            = state_q;
  assign RST_EVT          = rst_evt_q;
  assign RST_CNT          = rst_cnt_q;

endmodule
